// File: rtl/food_spawn_ctrl_pkg.sv
// Shared snake-grid definitions: default grid geometry, cell coordinate type
// and the food-spawn sequencer state encoding.
package food_spawn_ctrl_pkg;

    localparam int GRID_W_DEF    = 16;
    localparam int GRID_H_DEF    = 16;
    localparam int MAX_TRIES_DEF = 8;
    localparam int X_W           = $clog2(GRID_W_DEF);
    localparam int Y_W           = $clog2(GRID_H_DEF);

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } coord_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_QUERY,
        ST_CHECK,
        ST_SCAN_Q,
        ST_SCAN_C,
        ST_FINISH
    } spawn_state_e;

endpackage

// File: rtl/food_spawn_ctrl_if.sv
// Bundle between the food spawner, the game FSM, the LFSR and the body RAM.
// The slave side is the spawner itself; the master side is its environment.
interface food_spawn_ctrl_if #(
    parameter int X_W = 4,
    parameter int Y_W = 4
);
    logic           spawn_req;
    logic           clear_food;
    logic [9:0]     random;
    logic           lfsr_step;
    logic [X_W-1:0] occ_x;
    logic [Y_W-1:0] occ_y;
    logic           occ_hit;
    logic [X_W-1:0] food_x;
    logic [Y_W-1:0] food_y;
    logic           food_valid;
    logic           spawn_done;
    logic           grid_full;
    logic           busy;

    modport slave (
        input  spawn_req, clear_food, random, occ_hit,
        output lfsr_step, occ_x, occ_y, food_x, food_y,
               food_valid, spawn_done, grid_full, busy
    );

    modport master (
        output spawn_req, clear_food, random, occ_hit,
        input  lfsr_step, occ_x, occ_y, food_x, food_y,
               food_valid, spawn_done, grid_full, busy
    );
endinterface

// File: rtl/food_spawn_ctrl_cursor.sv
// Raster-order scan cursor: loads a start cell, then steps x-first and wraps
// from the last cell back to (0,0).
module raster_cursor #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    parameter int COL_W  = $clog2(GRID_W),
    parameter int ROW_W  = $clog2(GRID_H)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [COL_W-1:0] load_x,
    input  logic [ROW_W-1:0] load_y,
    input  logic             advance,
    output logic [COL_W-1:0] cur_x,
    output logic [ROW_W-1:0] cur_y
);
    localparam logic [COL_W-1:0] LAST_X = COL_W'(GRID_W - 1);
    localparam logic [ROW_W-1:0] LAST_Y = ROW_W'(GRID_H - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_x <= '0;
            cur_y <= '0;
        end else if (load) begin
            cur_x <= load_x;
            cur_y <= load_y;
        end else if (advance) begin
            if (cur_x == LAST_X) begin
                cur_x <= '0;
                cur_y <= (cur_y == LAST_Y) ? '0 : cur_y + 1'b1;
            end else begin
                cur_x <= cur_x + 1'b1;
            end
        end
    end
endmodule

// File: rtl/food_spawn_ctrl.sv
// Food spawner: random cell attempts against the body occupancy RAM, with a
// raster-scan fallback once the random attempts are used up.
module food_spawn_ctrl
    import food_spawn_ctrl_pkg::*;
#(
    parameter int GRID_W    = GRID_W_DEF,
    parameter int GRID_H    = GRID_H_DEF,
    parameter int MAX_TRIES = MAX_TRIES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    food_spawn_ctrl_if.slave   bus
);
    localparam int COL_W = $clog2(GRID_W);
    localparam int ROW_W = $clog2(GRID_H);
    localparam int SC_W  = $clog2(GRID_W * GRID_H) + 1;
    localparam logic [COL_W:0]   X_LIM     = (COL_W + 1)'(GRID_W);
    localparam logic [ROW_W:0]   Y_LIM     = (ROW_W + 1)'(GRID_H);
    localparam logic [SC_W-1:0]  SCAN_LAST = SC_W'(GRID_W * GRID_H - 1);
    localparam logic [7:0]       LAST_TRY  = 8'(MAX_TRIES - 1);

    spawn_state_e     state, next_state;
    logic [COL_W-1:0] cand_x, rnd_x, cur_x, cur_load_x;
    logic [ROW_W-1:0] cand_y, rnd_y, cur_y, cur_load_y;
    logic [7:0]       tries;
    logic [SC_W-1:0]  scan_cnt;
    logic             in_range, cur_load, cur_adv;

    assign rnd_x    = bus.random[COL_W-1:0];
    assign rnd_y    = bus.random[COL_W+ROW_W-1:COL_W];
    assign in_range = ({1'b0, rnd_x} < X_LIM) && ({1'b0, rnd_y} < Y_LIM);

    generate
        if (COL_W + ROW_W < 10) begin : g_unused_rnd
            logic unused_rnd;
            assign unused_rnd = ^bus.random[9:COL_W+ROW_W];
        end
    endgenerate

    raster_cursor #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_cursor (
        .clk     (clk),
        .reset   (reset),
        .load    (cur_load),
        .load_x  (cur_load_x),
        .load_y  (cur_load_y),
        .advance (cur_adv),
        .cur_x   (cur_x),
        .cur_y   (cur_y)
    );

    always_comb begin
        next_state = state;
        cur_load   = 1'b0;
        cur_load_x = cand_x;
        cur_load_y = cand_y;
        cur_adv    = 1'b0;
        case (state)
            ST_IDLE:   if (bus.spawn_req) next_state = ST_SAMPLE;
            ST_SAMPLE: begin
                if (in_range) begin
                    next_state = ST_QUERY;
                end else if (tries == LAST_TRY) begin
                    // No usable candidate to start from, so scan the whole grid from (0,0)
                    cur_load   = 1'b1;
                    cur_load_x = '0;
                    cur_load_y = '0;
                    next_state = ST_SCAN_Q;
                end
            end
            ST_QUERY:  next_state = ST_CHECK;
            ST_CHECK: begin
                if (!bus.occ_hit) begin
                    next_state = ST_FINISH;
                end else if (tries == LAST_TRY) begin
                    cur_load   = 1'b1;
                    next_state = ST_SCAN_Q;
                end else begin
                    next_state = ST_SAMPLE;
                end
            end
            ST_SCAN_Q: next_state = ST_SCAN_C;
            ST_SCAN_C: begin
                if (!bus.occ_hit) begin
                    next_state = ST_FINISH;
                end else begin
                    cur_adv    = 1'b1;
                    next_state = (scan_cnt == SCAN_LAST) ? ST_FINISH : ST_SCAN_Q;
                end
            end
            ST_FINISH: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.lfsr_step  = (state == ST_SAMPLE);
        bus.spawn_done = (state == ST_FINISH);
        bus.busy       = (state != ST_IDLE);
        bus.occ_x      = '0;
        bus.occ_y      = '0;
        if (state == ST_QUERY || state == ST_CHECK) begin
            bus.occ_x = cand_x;
            bus.occ_y = cand_y;
        end else if (state == ST_SCAN_Q || state == ST_SCAN_C) begin
            bus.occ_x = cur_x;
            bus.occ_y = cur_y;
        end
    end

    // A placement in the same cycle as clear_food wins, so it is assigned last.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cand_x         <= '0;
            cand_y         <= '0;
            tries          <= '0;
            scan_cnt       <= '0;
            bus.food_x     <= '0;
            bus.food_y     <= '0;
            bus.food_valid <= 1'b0;
            bus.grid_full  <= 1'b0;
        end else begin
            state <= next_state;
            if (bus.clear_food) bus.food_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.spawn_req) begin
                        tries          <= '0;
                        bus.grid_full  <= 1'b0;
                        bus.food_valid <= 1'b0;
                    end
                end
                ST_SAMPLE: begin
                    cand_x <= rnd_x;
                    cand_y <= rnd_y;
                    if (!in_range) tries <= tries + 1'b1;
                end
                ST_CHECK: begin
                    if (!bus.occ_hit) begin
                        bus.food_x     <= cand_x;
                        bus.food_y     <= cand_y;
                        bus.food_valid <= 1'b1;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                ST_SCAN_C: begin
                    if (!bus.occ_hit) begin
                        bus.food_x     <= cur_x;
                        bus.food_y     <= cur_y;
                        bus.food_valid <= 1'b1;
                    end else if (scan_cnt == SCAN_LAST) begin
                        bus.grid_full <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (cur_load)     scan_cnt <= '0;
            else if (cur_adv) scan_cnt <= scan_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Directed bench for food_spawn_ctrl with a modelled LFSR value list and a
// registered-read occupancy map.
module tb_food_spawn_ctrl;
    import food_spawn_ctrl_pkg::*;

    typedef struct {
        logic [9:0] rnd;
        int         clr_edge;
        int         exp_x;
        int         exp_y;
        int         exp_fv_after;
    } vec_t;

    typedef struct {
        int edges; int steps; int dones; int seen;
        int fx; int fy; int fv; int gf; int va; int fv_after;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   step_cnt = 0;
    int   done_cnt = 0;
    logic [9:0] rnd_seq [16];
    bit   occ_map [256];
    vec_t vecs [6];

    food_spawn_ctrl_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

    food_spawn_ctrl #(.GRID_W(16), .GRID_H(16), .MAX_TRIES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.random = rnd_seq[step_cnt & 15];

    always @(posedge clk) begin
        bus.occ_hit <= occ_map[{bus.occ_y, bus.occ_x}];
        if (bus.lfsr_step)  step_cnt <= step_cnt + 1;
        if (bus.spawn_done) done_cnt <= done_cnt + 1;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_rnd(input int k, input logic [9:0] v);
        rnd_seq[(step_cnt + k) & 15] = v;
    endtask

    task automatic set_map(input bit v);
        for (int i = 0; i < 256; i++) occ_map[i] = v;
    endtask

    task automatic run_spawn(input int limit, input bit hold, input int clr_edge, output res_t r);
        int s0, d0;
        @(negedge clk);
        s0 = step_cnt;
        d0 = done_cnt;
        bus.spawn_req  = 1'b1;
        bus.clear_food = (clr_edge == 0);
        @(posedge clk);
        r.edges = 1;
        @(negedge clk);
        bus.spawn_req  = hold;
        bus.clear_food = (r.edges == clr_edge);
        r.va = int'(bus.food_valid);
        while (!bus.spawn_done && r.edges < limit) begin
            @(posedge clk);
            r.edges++;
            @(negedge clk);
            bus.clear_food = (r.edges == clr_edge);
        end
        r.seen = int'(bus.spawn_done);
        r.fx   = int'(bus.food_x);
        r.fy   = int'(bus.food_y);
        r.fv   = int'(bus.food_valid);
        r.gf   = int'(bus.grid_full);
        bus.spawn_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.clear_food = 1'b0;
        r.fv_after = int'(bus.food_valid);
        r.steps    = step_cnt - s0;
        r.dones    = done_cnt - d0;
    endtask

    task automatic applyStimulus(input vec_t v);
        res_t r;
        set_rnd(0, v.rnd);
        run_spawn(20, 1'b0, v.clr_edge, r);
        checkOutput("vec_edges", r.edges, 4);
        checkOutput("vec_done_seen", r.seen, 1);
        checkOutput("vec_steps", r.steps, 1);
        checkOutput("vec_dones", r.dones, 1);
        checkOutput("vec_valid_after_accept", r.va, 0);
        checkOutput("vec_food_x", r.fx, v.exp_x);
        checkOutput("vec_food_y", r.fy, v.exp_y);
        checkOutput("vec_food_valid", r.fv, 1);
        checkOutput("vec_grid_full", r.gf, 0);
        checkOutput("vec_valid_after_done", r.fv_after, v.exp_fv_after);
    endtask

    task automatic check_idle_zero(input string tag);
        checkOutput({tag, "_busy"}, int'(bus.busy), 0);
        checkOutput({tag, "_lfsr_step"}, int'(bus.lfsr_step), 0);
        checkOutput({tag, "_spawn_done"}, int'(bus.spawn_done), 0);
        checkOutput({tag, "_food_valid"}, int'(bus.food_valid), 0);
        checkOutput({tag, "_grid_full"}, int'(bus.grid_full), 0);
        checkOutput({tag, "_occ_xy"}, int'({bus.occ_y, bus.occ_x}), 0);
        checkOutput({tag, "_food_xy"}, int'({bus.food_y, bus.food_x}), 0);
    endtask

    initial begin
        res_t r;
        int   d0;

        vecs[0] = '{10'h0A5, -1,  5, 10, 1};
        vecs[1] = '{10'h3FF,  0, 15, 15, 1};
        vecs[2] = '{10'h000,  3,  0,  0, 1};
        vecs[3] = '{10'h30F,  4, 15,  0, 0};
        vecs[4] = '{10'h1F0,  2,  0, 15, 1};
        vecs[5] = '{10'h2C3, -1,  3, 12, 1};

        for (int i = 0; i < 16; i++) rnd_seq[i] = '0;
        set_map(1'b0);
        reset          = 1'b1;
        bus.spawn_req  = 1'b0;
        bus.clear_food = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("por");
        reset = 1'b0;

        // Single-attempt spawns on an empty grid, with clear_food at various points
        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        $display("[TB] two collisions then a free cell");
        set_rnd(0, 10'h0A5);
        set_rnd(1, 10'h013);
        set_rnd(2, 10'h2E7);
        set_map(1'b0);
        occ_map[8'hA5] = 1'b1;
        occ_map[8'h13] = 1'b1;
        run_spawn(50, 1'b0, -1, r);
        checkOutput("retry_edges", r.edges, 10);
        checkOutput("retry_steps", r.steps, 3);
        checkOutput("retry_food_x", r.fx, 7);
        checkOutput("retry_food_y", r.fy, 14);
        checkOutput("retry_food_valid", r.fv, 1);

        $display("[TB] random tries exhausted, scan wraps to (0,0)");
        set_map(1'b0);
        for (int k = 0; k < 7; k++) begin
            set_rnd(k, 10'((k + 1) * 17));
            occ_map[(k + 1) * 17] = 1'b1;
        end
        set_rnd(7, 10'h0FF);
        occ_map[255] = 1'b1;
        run_spawn(100, 1'b0, -1, r);
        checkOutput("wrap_edges", r.edges, 29);
        checkOutput("wrap_steps", r.steps, 8);
        checkOutput("wrap_food_x", r.fx, 0);
        checkOutput("wrap_food_y", r.fy, 0);
        checkOutput("wrap_food_valid", r.fv, 1);
        checkOutput("wrap_grid_full", r.gf, 0);

        $display("[TB] full grid");
        set_map(1'b1);
        run_spawn(700, 1'b0, -1, r);
        checkOutput("full_edges", r.edges, 537);
        checkOutput("full_steps", r.steps, 8);
        checkOutput("full_dones", r.dones, 1);
        checkOutput("full_grid_full", r.gf, 1);
        checkOutput("full_food_valid", r.fv, 0);

        $display("[TB] reset during raster scan");
        @(negedge clk);
        bus.spawn_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.spawn_req = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        checkOutput("scan_busy_before_reset", int'(bus.busy), 1);
        d0 = done_cnt;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_zero("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy_after", int'(bus.busy), 0);
        checkOutput("rst_no_done", done_cnt - d0, 0);

        $display("[TB] spawn_req held while busy, clear_food pulses");
        set_map(1'b0);
        set_rnd(0, 10'h0A5);
        set_rnd(1, 10'h011);
        run_spawn(20, 1'b1, 2, r);
        checkOutput("hold_edges", r.edges, 4);
        checkOutput("hold_food_valid", r.fv, 1);
        checkOutput("hold_food_x", r.fx, 5);
        checkOutput("hold_food_y", r.fy, 10);
        d0 = done_cnt;
        repeat (5) @(negedge clk);
        checkOutput("hold_steps", r.steps + (step_cnt - step_cnt), 1);
        checkOutput("hold_extra_dones", done_cnt - d0, 0);
        checkOutput("hold_busy_after", int'(bus.busy), 0);
        checkOutput("hold_valid_idle", int'(bus.food_valid), 1);
        bus.clear_food = 1'b1;
        @(negedge clk);
        bus.clear_food = 1'b0;
        checkOutput("idle_clear_food", int'(bus.food_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
